// File: rtl/micro_sequencer.sv
// Micro-sequencer: owns the micro-PC, fetches micro-instructions from the
// micro-ROM over a valid handshake, steps them through DECODE/EXECUTE1/EXECUTE2,
// resolves branches at the end of EXECUTE2 and handles run/halt control.
`timescale 1ns/1ps

module micro_sequencer #(
  parameter int UPC_WIDTH    = 10,
  parameter int UINSTR_WIDTH = 44,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset_n,
  input  logic                    run,
  input  logic                    halt_req,
  output logic                    rom_rd_en,
  output logic [UPC_WIDTH-1:0]    rom_addr,
  input  logic [UINSTR_WIDTH-1:0] rom_data,
  input  logic                    rom_valid,
  output logic [UINSTR_WIDTH-1:0] uinstr,
  output logic                    uinstr_valid,
  output logic [2:0]              cpu_state,
  input  logic                    is_branch,
  input  logic [UPC_WIDTH-1:0]    branch_target,
  input  logic                    branch_cond,
  output logic [UPC_WIDTH-1:0]    upc,
  output logic                    halted,
  output logic [CNT_WIDTH-1:0]    retire_cnt
);

  // Encodings are shared with the downstream decode stage; do not renumber.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXECUTE1 = 3'd3,
    EXECUTE2 = 3'd4,
    HALTED   = 3'd5
  } state_t;

  state_t state;
  logic   halt_pending;

  // The ROM is always addressed by the current micro-PC.
  assign rom_addr  = upc;
  assign cpu_state = state;

  // Sequencer FSM: state, micro-PC, instruction latch, retire counter and the
  // registered strobes (each strobe is raised together with entry to its state).
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state        <= IDLE;
      upc          <= '0;
      uinstr       <= '0;
      retire_cnt   <= '0;
      halt_pending <= 1'b0;
      rom_rd_en    <= 1'b0;
      uinstr_valid <= 1'b0;
      halted       <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see the pre-edge
      // values; the strobes default low and each branch raises only its own.
      rom_rd_en    <= 1'b0;
      uinstr_valid <= 1'b0;
      halted       <= 1'b0;

      // A halt request seen mid-instruction is remembered until EXECUTE2;
      // the in-flight micro-instruction always completes.
      if (halt_req && (state == FETCH || state == DECODE || state == EXECUTE1)) begin
        halt_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (run) begin
            state     <= FETCH;
            rom_rd_en <= 1'b1;
          end
        end

        FETCH: begin
          if (rom_valid) begin
            uinstr       <= rom_data;
            state        <= DECODE;
            uinstr_valid <= 1'b1;
          end else begin
            rom_rd_en <= 1'b1;
          end
        end

        DECODE: begin
          state <= EXECUTE1;
        end

        EXECUTE1: begin
          state <= EXECUTE2;
        end

        EXECUTE2: begin
          retire_cnt <= retire_cnt + 1'b1;
          if (is_branch && branch_cond) begin
            upc <= branch_target;
          end else begin
            upc <= upc + 1'b1;
          end
          if (halt_pending || halt_req) begin
            state        <= HALTED;
            halted       <= 1'b1;
            halt_pending <= 1'b0;
          end else begin
            state     <= FETCH;
            rom_rd_en <= 1'b1;
          end
        end

        HALTED: begin
          if (run && !halt_req) begin
            state     <= FETCH;
            rom_rd_en <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model of the instruction life cycle.
`timescale 1ns/1ps

module tb_micro_sequencer;

  localparam int UPC_W   = 10;
  localparam int UI_W    = 44;
  localparam int CNT_W   = 16;
  localparam int S_CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n, run, halt_req, rom_valid, is_branch, branch_cond;
  logic [UI_W-1:0]   rom_data;
  logic [UPC_W-1:0]  branch_target;

  logic              rom_rd_en, uinstr_valid, halted;
  logic [UPC_W-1:0]  rom_addr, upc;
  logic [UI_W-1:0]   uinstr;
  logic [2:0]        cpu_state;
  logic [CNT_W-1:0]  retire_cnt;

  // Second instance with a narrow retire counter so counter wrap is reachable.
  logic              s_rom_rd_en, s_uinstr_valid, s_halted;
  logic [UPC_W-1:0]  s_rom_addr, s_upc;
  logic [UI_W-1:0]   s_uinstr;
  logic [2:0]        s_cpu_state;
  logic [S_CNT_W-1:0] s_retire_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  micro_sequencer #(.UPC_WIDTH(UPC_W), .UINSTR_WIDTH(UI_W), .CNT_WIDTH(CNT_W)) dut (
    .sys_clk(clk), .sys_reset_n(rst_n), .run(run), .halt_req(halt_req),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .uinstr(uinstr), .uinstr_valid(uinstr_valid), .cpu_state(cpu_state),
    .is_branch(is_branch), .branch_target(branch_target), .branch_cond(branch_cond),
    .upc(upc), .halted(halted), .retire_cnt(retire_cnt)
  );

  micro_sequencer #(.UPC_WIDTH(UPC_W), .UINSTR_WIDTH(UI_W), .CNT_WIDTH(S_CNT_W)) dut_small (
    .sys_clk(clk), .sys_reset_n(rst_n), .run(run), .halt_req(halt_req),
    .rom_rd_en(s_rom_rd_en), .rom_addr(s_rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .uinstr(s_uinstr), .uinstr_valid(s_uinstr_valid), .cpu_state(s_cpu_state),
    .is_branch(is_branch), .branch_target(branch_target), .branch_cond(branch_cond),
    .upc(s_upc), .halted(s_halted), .retire_cnt(s_retire_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks where the current micro-instruction is in its
  // life (waiting on ROM, or N cycles after acceptance) rather than a state code.
  // ---------------------------------------------------------------------------
  bit              m_active  = 1'b0;  // started and not halted
  bit              m_halted  = 1'b0;
  bit              m_waiting = 1'b0;  // waiting for ROM data
  bit              m_halt_hp = 1'b0;  // halt requested during this instruction
  int              m_age     = 0;     // cycles since ROM data accepted (1..3)
  int unsigned     m_pc      = 0;
  logic [UI_W-1:0] m_instr   = '0;
  int unsigned     m_retired = 0;

  function automatic logic [2:0] exp_state();
    if (m_halted)  return 3'd5;
    if (!m_active) return 3'd0;
    if (m_waiting) return 3'd1;
    return 3'(1 + m_age);
  endfunction

  // Advance the model on each clock edge using the inputs the DUT samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_halted = 0; m_waiting = 0; m_halt_hp = 0;
      m_age = 0; m_pc = 0; m_instr = '0; m_retired = 0;
    end else if (m_halted) begin
      if (run && !halt_req) begin
        m_halted = 0; m_active = 1; m_waiting = 1;
      end
    end else if (!m_active) begin
      if (run) begin
        m_active = 1; m_waiting = 1;
      end
    end else begin
      if (halt_req) m_halt_hp = 1;
      if (m_waiting) begin
        if (rom_valid) begin
          m_waiting = 0; m_age = 1; m_instr = rom_data;
        end
      end else if (m_age < 3) begin
        m_age++;
      end else begin
        m_pc = (is_branch && branch_cond) ? branch_target : (m_pc + 1) % 1024;
        m_retired++;
        if (m_halt_hp) begin
          m_halted = 1; m_active = 0; m_halt_hp = 0;
        end else begin
          m_waiting = 1;
        end
      end
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_state",    cpu_state,    exp_state());
      check("upc",          upc,          m_pc);
      check("rom_addr",     rom_addr,     m_pc);
      check("rom_rd_en",    rom_rd_en,    exp_state() == 3'd1);
      check("uinstr_valid", uinstr_valid, exp_state() == 3'd2);
      check("halted",       halted,       exp_state() == 3'd5);
      check("uinstr",       uinstr,       m_instr);
      check("retire_cnt",   retire_cnt,   CNT_W'(m_retired));
      check("small_retire_cnt", s_retire_cnt, S_CNT_W'(m_retired));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; run = 1; rom_valid = 1; halt_req = 0;
    is_branch = 0; branch_cond = 0; branch_target = '0; rom_data = '0;

    // Reset dominates run and rom_valid.
    repeat (3) step();
    chk_en = 1'b1;
    check("t1_state", cpu_state, 0);
    check("t1_upc", upc, 0);
    check("t1_rd_en", rom_rd_en, 0);
    check("t1_retire", retire_cnt, 0);

    rst_n = 1; run = 0;
    step();
    run = 1;
    step();
    run = 0;

    // Zero-wait fetches: addresses 0,1,2 every four cycles.
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        check("t2_fetch_state", cpu_state, 1);
        check("t2_rom_addr", rom_addr, i / 4);
      end
      if (i % 4 == 1) check("t2_uinstr_valid", uinstr_valid, 1);
      if (i % 4 == 2) check("t2_uinstr_valid_drop", uinstr_valid, 0);
      step();
    end
    check("t2_retire", retire_cnt, 3);

    // ROM answers after three wait cycles; request held stable meanwhile.
    rom_valid = 0;
    rom_data  = 44'hABC_DEF01234;
    for (int k = 0; k < 4; k++) begin
      check("t3_state", cpu_state, 1);
      check("t3_rd_en", rom_rd_en, 1);
      check("t3_addr", rom_addr, 3);
      if (k == 3) rom_valid = 1;
      step();
    end
    check("t3_decode", cpu_state, 2);
    check("t3_uinstr", uinstr, 44'hABC_DEF01234);
    check("t3_uvalid", uinstr_valid, 1);

    // Taken branch, then not-taken branch.
    is_branch = 1; branch_cond = 1; branch_target = 10'h3F0;
    step();
    check("t3_uinstr_held", uinstr, 44'hABC_DEF01234);
    step(); step();
    check("t4_taken_state", cpu_state, 1);
    check("t4_taken_addr", rom_addr, 10'h3F0);
    branch_cond = 0;
    repeat (4) step();
    check("t4_not_taken_addr", rom_addr, 10'h3F1);

    // Micro-PC wrap and narrow counter wrap.
    branch_cond = 1; branch_target = 10'h3FF;
    repeat (4) step();
    check("t5_addr_3ff", rom_addr, 10'h3FF);
    is_branch = 0;
    repeat (4) step();
    check("t5_upc_wrap", upc, 0);
    check("t5_retire", retire_cnt, 7);
    check("t5_small_retire", s_retire_cnt, 7);
    repeat (4) step();
    check("t5_retire8", retire_cnt, 8);
    check("t5_small_wrap", s_retire_cnt, 0);
    check("t5_upc1", upc, 1);

    // Halt pulse in DECODE at upc 5.
    is_branch = 1; branch_cond = 1; branch_target = 10'd5;
    repeat (4) step();
    check("t6_addr5", rom_addr, 5);
    is_branch = 0;
    step();
    check("t6_decode", cpu_state, 2);
    halt_req = 1;
    step();
    halt_req = 0;
    check("t6_exec1", cpu_state, 3);
    step();
    check("t6_exec2", cpu_state, 4);
    step();
    check("t6_halted_state", cpu_state, 5);
    check("t6_halted", halted, 1);
    check("t6_upc", upc, 6);
    step();
    check("t6_still_halted", cpu_state, 5);
    run = 1;
    step();
    run = 0;
    check("t6_resume_state", cpu_state, 1);
    check("t6_resume_addr", rom_addr, 6);

    // Reset in the middle of a stalled fetch; a late rom_valid is ignored.
    rom_valid = 0;
    step();
    check("t6_stall", cpu_state, 1);
    rst_n = 0; rom_valid = 1;
    step();
    check("t6_rst_state", cpu_state, 0);
    check("t6_rst_rd_en", rom_rd_en, 0);
    rst_n = 1;
    step();
    check("t6_after_rst", cpu_state, 0);
    check("t6_after_rst_rd", rom_rd_en, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      run           = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 15) == 0);
      rom_valid     = $urandom_range(0, 1);
      rom_data      = {12'($urandom), $urandom};
      is_branch     = $urandom_range(0, 1);
      branch_cond   = $urandom_range(0, 1);
      branch_target = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
